// File: rtl/rc5_pkg.sv
// Shared RC5 definitions: decryptor FSM state encodings and the RC5 magic constants
// (P_W, Q_W) for every supported word width, so key-mixer benches can reuse them.
package rc5_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_WAIT = 3'd2,
      ST_SUB  = 3'd3,
      ST_ROTX = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   localparam logic [15:0] P_W16 = 16'hB7E1;
   localparam logic [15:0] Q_W16 = 16'h9E37;
   localparam logic [31:0] P_W32 = 32'hB7E15163;
   localparam logic [31:0] Q_W32 = 32'h9E3779B9;
   localparam logic [63:0] P_W64 = 64'hB7E151628AED2A6B;
   localparam logic [63:0] Q_W64 = 64'h9E3779B97F4A7C15;

   function automatic logic [63:0] magic_p(input int w);
      case (w)
         16:      return {48'd0, P_W16};
         64:      return P_W64;
         default: return {32'd0, P_W32};
      endcase
   endfunction

   function automatic logic [63:0] magic_q(input int w);
      case (w)
         16:      return {48'd0, Q_W16};
         64:      return Q_W64;
         default: return {32'd0, Q_W32};
      endcase
   endfunction

endpackage

// File: rtl/rc5_rotate.sv
// Combinational logarithmic barrel rotator; dir=1 rotates left, dir=0 rotates right.
module rc5_rotate #(
   parameter int W        = 32,
   parameter int ROTVALUE = $clog2(W)
) (
   input  logic [W-1:0]        value,
   input  logic                dir,
   input  logic [ROTVALUE-1:0] amount,
   output logic [W-1:0]        result
);

   logic [W-1:0] stage [0:ROTVALUE];

   assign stage[0] = value;

   genvar gi;
   generate
      for (gi = 0; gi < ROTVALUE; gi++) begin : g_stage
         localparam int SH = 1 << gi;
         logic [W-1:0] left;
         logic [W-1:0] right;
         assign left  = {stage[gi][W-SH-1:0], stage[gi][W-1:W-SH]};
         assign right = {stage[gi][SH-1:0], stage[gi][W-1:SH]};
         assign stage[gi+1] = amount[gi] ? (dir ? left : right) : stage[gi];
      end
   endgenerate

   assign result = stage[ROTVALUE];

endmodule

// File: rtl/rc5_decryptor.sv
// Iterative RC5-W/R block decryptor reading the expanded key table through a synchronous S port.
// Define RC5_ENC_MODE_EN to add the iMode input and an encryption walk over the same datapath.
module rc5_decryptor
   import rc5_pkg::*;
#(
   parameter int W        = 32,
   parameter int R        = 12,
   parameter int T        = 2*R+2,
   parameter int T_LENGTH = $clog2(T),
   parameter int ROTVALUE = $clog2(W)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                iStart,
`ifdef RC5_ENC_MODE_EN
   input  logic                iMode,
`endif
   input  logic [W-1:0]        iA,
   input  logic [W-1:0]        iB,
   output logic [T_LENGTH-1:0] oS_address,
   input  logic [W-1:0]        iS_sub_i,
   output logic [W-1:0]        oA,
   output logic [W-1:0]        oB,
   output logic                oBusy,
   output logic                oDone
);

   localparam logic [T_LENGTH-1:0] K_LAST = T_LENGTH'(T-1);

   state_t              state_reg, state_next;
   logic [W-1:0]        a_reg, a_next, b_reg, b_next, tmp_reg, tmp_next;
   logic [W-1:0]        oa_next, ob_next;
   logic [T_LENGTH-1:0] k_reg, k_next, addr_next, start_k, k_step;
   logic                busy_next, done_next, enc;
   logic                odd, k_ge2, k_end;
   logic [W-1:0]        x_word, partner, rot_in, rot_out, arith;

`ifdef RC5_ENC_MODE_EN
   logic enc_reg, enc_next;
   assign enc     = enc_reg;
   assign start_k = iMode ? '0 : K_LAST;
`else
   assign enc     = 1'b0;
   assign start_k = K_LAST;
`endif

   // Odd k works on B with A as partner, even k the other way round.
   assign odd     = k_reg[0];
   assign x_word  = odd ? b_reg : a_reg;
   assign partner = odd ? a_reg : b_reg;
   assign k_ge2   = (k_reg >= T_LENGTH'(2));
   assign k_end   = enc ? (k_reg == K_LAST) : (k_reg == '0);
   assign k_step  = enc ? (k_reg + T_LENGTH'(1)) : (k_reg - T_LENGTH'(1));
   assign rot_in  = enc ? (x_word ^ partner) : tmp_reg;
   assign arith   = enc ? ((k_ge2 ? tmp_reg : x_word) + iS_sub_i) : (x_word - iS_sub_i);

   rc5_rotate #(.W(W), .ROTVALUE(ROTVALUE)) u_rotate (
      .value  (rot_in),
      .dir    (enc),
      .amount (partner[ROTVALUE-1:0]),
      .result (rot_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         tmp_reg    <= '0;
         k_reg      <= K_LAST;
         oS_address <= K_LAST;
         oA         <= '0;
         oB         <= '0;
         oBusy      <= 1'b0;
         oDone      <= 1'b0;
`ifdef RC5_ENC_MODE_EN
         enc_reg    <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         tmp_reg    <= tmp_next;
         k_reg      <= k_next;
         oS_address <= addr_next;
         oA         <= oa_next;
         oB         <= ob_next;
         oBusy      <= busy_next;
         oDone      <= done_next;
`ifdef RC5_ENC_MODE_EN
         enc_reg    <= enc_next;
`endif
      end
   end

   // Decrypt subtracts before rotating; encrypt rotates first and adds S in SUB.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (iStart) state_next = ST_ADDR;
         ST_ADDR: state_next = ST_WAIT;
         ST_WAIT: state_next = (enc && k_ge2) ? ST_ROTX : ST_SUB;
         ST_SUB: begin
            if (!enc && k_ge2) state_next = ST_ROTX;
            else if (k_end)    state_next = ST_DONE;
            else               state_next = ST_ADDR;
         end
         ST_ROTX: state_next = enc ? ST_SUB : ST_ADDR;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      a_next    = a_reg;
      b_next    = b_reg;
      tmp_next  = tmp_reg;
      k_next    = k_reg;
      addr_next = oS_address;
      oa_next   = oA;
      ob_next   = oB;
      busy_next = oBusy;
      done_next = 1'b0;
`ifdef RC5_ENC_MODE_EN
      enc_next  = enc_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (iStart) begin
               a_next    = iA;
               b_next    = iB;
               k_next    = start_k;
               addr_next = start_k;
               busy_next = 1'b1;
`ifdef RC5_ENC_MODE_EN
               enc_next  = iMode;
`endif
            end
         end
         ST_SUB: begin
            if (!enc && k_ge2) begin
               tmp_next = arith;
            end else begin
               if (odd) b_next = arith;
               else     a_next = arith;
               if (!k_end) begin
                  k_next    = k_step;
                  addr_next = k_step;
               end
            end
         end
         ST_ROTX: begin
            if (enc) begin
               tmp_next = rot_out;
            end else begin
               if (odd) b_next = rot_out ^ partner;
               else     a_next = rot_out ^ partner;
               k_next    = k_step;
               addr_next = k_step;
            end
         end
         default: ;
      endcase
      // Results and the strobe are loaded on the edge that enters DONE.
      if (state_reg != ST_DONE && state_next == ST_DONE) begin
         oa_next   = a_next;
         ob_next   = b_next;
         done_next = 1'b1;
         busy_next = 1'b0;
      end
   end

endmodule

// File: tb/tb_rc5_decryptor.sv
// Directed bench for rc5_decryptor (RC5-32/12) with a synchronous S RAM and a software RC5 model.
module tb_rc5_decryptor;

   localparam logic [31:0] P32 = 32'hB7E15163;
   localparam logic [31:0] Q32 = 32'h9E3779B9;

   logic        clk, rst_n, iStart;
   logic [31:0] iA, iB, iS_sub_i, oA, oB;
   logic [4:0]  oS_address;
   logic        oBusy, oDone;
`ifdef RC5_ENC_MODE_EN
   logic        iMode;
`endif

   logic [31:0] s_mem [0:25];
   int checks = 0;
   int errors = 0;

   rc5_decryptor dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .iStart     (iStart),
`ifdef RC5_ENC_MODE_EN
      .iMode      (iMode),
`endif
      .iA         (iA),
      .iB         (iB),
      .oS_address (oS_address),
      .iS_sub_i   (iS_sub_i),
      .oA         (oA),
      .oB         (oB),
      .oBusy      (oBusy),
      .oDone      (oDone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) iS_sub_i <= s_mem[oS_address];

   function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] n);
      int sh = int'(n);
      if (sh == 0) return v;
      return (v << sh) | (v >> (32 - sh));
   endfunction

   function automatic logic [31:0] rotr32(input logic [31:0] v, input logic [4:0] n);
      int sh = int'(n);
      if (sh == 0) return v;
      return (v >> sh) | (v << (32 - sh));
   endfunction

   task automatic init_zero_key();
      logic [31:0] l [0:3];
      logic [31:0] a, b;
      int i, j;
      s_mem[0] = P32;
      for (int n = 1; n < 26; n++) s_mem[n] = s_mem[n-1] + Q32;
      for (int n = 0; n < 4; n++) l[n] = '0;
      a = '0; b = '0; i = 0; j = 0;
      for (int n = 0; n < 78; n++) begin
         s_mem[i] = rotl32(s_mem[i] + a + b, 5'd3);
         a = s_mem[i];
         l[j] = rotl32(l[j] + a + b, 5'(a + b));
         b = l[j];
         i = (i + 1) % 26;
         j = (j + 1) % 4;
      end
   endtask

   task automatic model_dec(input logic [31:0] a_in, b_in, output logic [31:0] a_o, b_o);
      logic [31:0] a = a_in, b = b_in;
      for (int i = 12; i >= 1; i--) begin
         b = rotr32(b - s_mem[2*i+1], a[4:0]) ^ a;
         a = rotr32(a - s_mem[2*i], b[4:0]) ^ b;
      end
      b_o = b - s_mem[1];
      a_o = a - s_mem[0];
   endtask

   // Drives one block; reports latency, result, strobe count and address/busy mismatches.
   task automatic run_block(input logic [31:0] a, b, input logic mode_i,
                            input int pulse_at, input int reset_at,
                            output logic [31:0] ra, rb, output int lat, output int ndone,
                            output int addr_err, output int busy_err);
      int exp_addr [$];
      for (int n = 0; n < 26; n++) begin
         int k = mode_i ? n : 25 - n;
         repeat ((k >= 2) ? 4 : 3) exp_addr.push_back(k);
      end
      ra = '0; rb = '0; lat = -1; ndone = 0; addr_err = 0; busy_err = 0;
      iA = a; iB = b; iStart = 1'b1;
`ifdef RC5_ENC_MODE_EN
      iMode = mode_i;
`endif
      @(posedge clk); #1;
      iStart = 1'b0;
      for (int c = 0; c < 160; c++) begin
         if (pulse_at >= 0 && c == pulse_at) begin iStart = 1'b1; iA = ~a; iB = ~b; end
         if (pulse_at >= 0 && c == pulse_at + 1) iStart = 1'b0;
         if (reset_at >= 0 && c == reset_at) rst_n = 1'b0;
         if (reset_at >= 0 && c == reset_at + 2) rst_n = 1'b1;
         if (reset_at < 0 || c < reset_at) begin
            if (c < 102 && oS_address !== 5'(exp_addr[c])) addr_err++;
            if (oBusy !== logic'(c < 102)) busy_err++;
         end
         if (oDone === 1'b1) begin
            ndone++;
            if (lat < 0) begin lat = c; ra = oA; rb = oB; end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; iStart = 1'b0; iA = '0; iB = '0;
`ifdef RC5_ENC_MODE_EN
      iMode = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      checks++; if (oS_address !== 5'd25) begin errors++; $display("FAIL reset_addr: got %0d expected 25", oS_address); end
      checks++; if (oA !== 32'h0) begin errors++; $display("FAIL reset_oA: got %h expected 0", oA); end
      checks++; if (oB !== 32'h0) begin errors++; $display("FAIL reset_oB: got %h expected 0", oB); end
      checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", oBusy); end
      checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", oDone); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      $display("reset: addr=%0d busy=%b done=%b", oS_address, oBusy, oDone);
   endtask

   task automatic test_zero_vector();
      logic [31:0] ra, rb; int lat, nd, ae, be;
      run_block(32'hEEDBA521, 32'h6D8F4B15, 1'b0, -1, -1, ra, rb, lat, nd, ae, be);
      $display("zero_vector: lat=%0d A=%h B=%h dones=%0d", lat, ra, rb, nd);
      checks++; if (lat !== 102) begin errors++; $display("FAIL zero_latency: got %0d expected 102", lat); end
      checks++; if (ra !== 32'h0) begin errors++; $display("FAIL zero_oA: got %h expected 00000000", ra); end
      checks++; if (rb !== 32'h0) begin errors++; $display("FAIL zero_oB: got %h expected 00000000", rb); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", nd); end
      checks++; if (ae !== 0) begin errors++; $display("FAIL zero_addr_seq: got %0d bad cycles expected 0", ae); end
      checks++; if (be !== 0) begin errors++; $display("FAIL zero_busy: got %0d bad cycles expected 0", be); end
   endtask

   task automatic test_chained();
      logic [31:0] ra, rb, ea, eb; int lat, nd, ae, be;
      model_dec(32'hF7C013AC, 32'h5B2B8952, ea, eb);
      run_block(32'hF7C013AC, 32'h5B2B8952, 1'b0, -1, -1, ra, rb, lat, nd, ae, be);
      $display("chained: lat=%0d A=%h B=%h exp %h %h", lat, ra, rb, ea, eb);
      checks++; if (ra !== ea) begin errors++; $display("FAIL chained_oA: got %h expected %h", ra, ea); end
      checks++; if (rb !== eb) begin errors++; $display("FAIL chained_oB: got %h expected %h", rb, eb); end
      checks++; if (ae !== 0) begin errors++; $display("FAIL chained_addr_seq: got %0d bad cycles expected 0", ae); end
      checks++; if (lat !== 102) begin errors++; $display("FAIL chained_latency: got %0d expected 102", lat); end
   endtask

   task automatic test_reset_abort();
      logic [31:0] ra, rb; int lat, nd, ae, be;
      run_block(32'hEEDBA521, 32'h6D8F4B15, 1'b0, -1, 50, ra, rb, lat, nd, ae, be);
      $display("abort: dones=%0d addr=%0d busy=%b oA=%h", nd, oS_address, oBusy, oA);
      checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", nd); end
      checks++; if (oA !== 32'h0) begin errors++; $display("FAIL abort_oA: got %h expected 0", oA); end
      checks++; if (oS_address !== 5'd25) begin errors++; $display("FAIL abort_addr: got %0d expected 25", oS_address); end
      checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", oBusy); end
      run_block(32'hEEDBA521, 32'h6D8F4B15, 1'b0, -1, -1, ra, rb, lat, nd, ae, be);
      $display("after_abort: lat=%0d A=%h B=%h", lat, ra, rb);
      checks++; if (lat !== 102) begin errors++; $display("FAIL rerun_latency: got %0d expected 102", lat); end
      checks++; if (ra !== 32'h0 || rb !== 32'h0) begin errors++; $display("FAIL rerun_result: got %h %h expected 0 0", ra, rb); end
   endtask

   task automatic test_ignore_start();
      logic [31:0] ra, rb; int lat, nd, ae, be;
      run_block(32'hEEDBA521, 32'h6D8F4B15, 1'b0, 40, -1, ra, rb, lat, nd, ae, be);
      $display("ignore_start: lat=%0d dones=%0d A=%h B=%h", lat, nd, ra, rb);
      checks++; if (nd !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", nd); end
      checks++; if (lat !== 102) begin errors++; $display("FAIL ignore_latency: got %0d expected 102", lat); end
      checks++; if (ra !== 32'h0 || rb !== 32'h0) begin errors++; $display("FAIL ignore_result: got %h %h expected 0 0", ra, rb); end
   endtask

   task automatic test_rotate_bounds();
      logic [31:0] ra, rb, ea, eb; int lat, nd, ae, be;
      for (int n = 0; n < 26; n++) s_mem[n] = '0;
      run_block(32'h0, 32'h0, 1'b0, -1, -1, ra, rb, lat, nd, ae, be);
      $display("rot_zero: A=%h B=%h", ra, rb);
      checks++; if (ra !== 32'h0 || rb !== 32'h0) begin errors++; $display("FAIL rot_identity: got %h %h expected 0 0", ra, rb); end
      for (int n = 0; n < 26; n++) s_mem[n] = (n % 2) ? 32'h0000001F : 32'h0;
      model_dec(32'h0000001F, 32'h0000001F, ea, eb);
      run_block(32'h0000001F, 32'h0000001F, 1'b0, -1, -1, ra, rb, lat, nd, ae, be);
      $display("rot_31: A=%h B=%h exp %h %h", ra, rb, ea, eb);
      checks++; if (ra !== ea || rb !== eb) begin errors++; $display("FAIL rot_31: got %h %h expected %h %h", ra, rb, ea, eb); end
      for (int n = 0; n < 26; n++) s_mem[n] = 32'hFFFFFFFF;
      model_dec(32'hFFFFFFE0, 32'h00000020, ea, eb);
      run_block(32'hFFFFFFE0, 32'h00000020, 1'b0, -1, -1, ra, rb, lat, nd, ae, be);
      $display("rot_wrap: A=%h B=%h exp %h %h", ra, rb, ea, eb);
      checks++; if (ra !== ea || rb !== eb) begin errors++; $display("FAIL rot_wrap: got %h %h expected %h %h", ra, rb, ea, eb); end
      init_zero_key();
   endtask

   task automatic test_back_to_back();
      logic [31:0] ea, eb, r1a, r2a, r2b, mida;
      int d1 = -1, d2 = -1, nd = 0;
      model_dec(32'h12345678, 32'h9ABCDEF0, ea, eb);
      r1a = '0; r2a = '0; r2b = '0; mida = '0;
      iA = 32'hEEDBA521; iB = 32'h6D8F4B15; iStart = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 260; c++) begin
         if (c == 103) begin iA = 32'h12345678; iB = 32'h9ABCDEF0; end
         if (c == 110) iStart = 1'b0;
         if (c == 150) mida = oA;
         if (oDone === 1'b1) begin
            nd++;
            if (d1 < 0) begin d1 = c; r1a = oA; end
            else if (d2 < 0) begin d2 = c; r2a = oA; r2b = oB; end
         end
         @(posedge clk); #1;
      end
      $display("back_to_back: d1=%0d d2=%0d A1=%h A2=%h B2=%h", d1, d2, r1a, r2a, r2b);
      checks++; if (d1 !== 102) begin errors++; $display("FAIL b2b_first_done: got %0d expected 102", d1); end
      checks++; if (d2 !== 206) begin errors++; $display("FAIL b2b_second_done: got %0d expected 206", d2); end
      checks++; if (mida !== 32'h0) begin errors++; $display("FAIL b2b_hold: got %h expected 00000000", mida); end
      checks++; if (r2a !== ea || r2b !== eb) begin errors++; $display("FAIL b2b_second_result: got %h %h expected %h %h", r2a, r2b, ea, eb); end
      checks++; if (nd !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", nd); end
   endtask

`ifdef RC5_ENC_MODE_EN
   task automatic test_encrypt();
      logic [31:0] ra, rb, da, db; int lat, nd, ae, be;
      run_block(32'h0, 32'h0, 1'b1, -1, -1, ra, rb, lat, nd, ae, be);
      $display("encrypt: lat=%0d A=%h B=%h", lat, ra, rb);
      checks++; if (ra !== 32'hEEDBA521 || rb !== 32'h6D8F4B15) begin errors++; $display("FAIL enc_result: got %h %h expected eedba521 6d8f4b15", ra, rb); end
      checks++; if (lat !== 102) begin errors++; $display("FAIL enc_latency: got %0d expected 102", lat); end
      checks++; if (ae !== 0) begin errors++; $display("FAIL enc_addr_seq: got %0d bad cycles expected 0", ae); end
      run_block(ra, rb, 1'b0, -1, -1, da, db, lat, nd, ae, be);
      $display("roundtrip: A=%h B=%h", da, db);
      checks++; if (da !== 32'h0 || db !== 32'h0) begin errors++; $display("FAIL enc_roundtrip: got %h %h expected 0 0", da, db); end
   endtask
`endif

   initial begin
      init_zero_key();
      test_reset();
      test_zero_vector();
      test_chained();
      test_reset_abort();
      test_ignore_start();
      test_rotate_bounds();
      test_back_to_back();
`ifdef RC5_ENC_MODE_EN
      test_encrypt();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
